// File: rtl/cpu_run_controller_pkg.sv
// Shared types for the run/halt/single-step controller: the sequencer state
// encoding that is also driven straight onto the state output.
package cpu_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_e;

    function automatic logic is_stopped(input run_state_e st);
        return (st == ST_HALT) || (st == ST_BREAK);
    endfunction

    function automatic logic is_executing(input run_state_e st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_run_controller_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on the rising edge of the accepted level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 45000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differs;
    logic          accept;

    // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        differs = (sync2_q != level_q);
        accept  = differs && (cnt_q == CNT_LAST);
        if (accept) begin
            level_d = sync2_q;
        end else if (differs) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // The pulse is taken from the accept condition so it coincides with the edge that raises the level.
    assign rise_pulse = accept & sync2_q & ~reset;
    assign level      = level_q;

    // NOTE: state flops use non-blocking assignments so every flop samples its pre-edge inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer producing the core clock enable, with a PC
// breakpoint and a free-running count of enabled cycles.
module cpu_run_controller
    import cpu_run_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 45000,
    parameter int STEP_CYCLES     = 1,
    parameter int PC_WIDTH        = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                btn_run,
    input  logic                btn_step,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] bp_addr,
    input  logic                bp_enable,
    output logic                cpu_en,
    output logic [1:0]          state,
    output logic [31:0]         cycle_cnt
);

    localparam int SW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);
    localparam logic [SW-1:0] STEP_LOAD = SW'(STEP_CYCLES);

    logic run_p, step_p;
    logic run_level_unused, step_level_unused;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .clock      (clock),
        .reset      (reset),
        .raw        (btn_run),
        .level      (run_level_unused),
        .rise_pulse (run_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock      (clock),
        .reset      (reset),
        .raw        (btn_step),
        .level      (step_level_unused),
        .rise_pulse (step_p)
    );

    run_state_e    state_q, state_d;
    logic [SW-1:0] step_left_q, step_left_d;
    logic          bp_skip_q, bp_skip_d;
    logic [31:0]   cycle_cnt_q, cycle_cnt_d;
    logic          at_bp;
    logic          bp_hit;
    logic          cpu_en_w;

    always_comb begin
        at_bp       = (pc == bp_addr);
        bp_hit      = bp_enable & at_bp & ~bp_skip_q;
        // The breakpointed instruction is held off in the very cycle the match is seen.
        cpu_en_w    = ~reset & (((state_q == ST_RUN) & ~bp_hit) | (state_q == ST_STEP));
        state_d     = state_q;
        step_left_d = step_left_q;
        bp_skip_d   = bp_skip_q;

        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (run_p) begin
                    state_d = ST_RUN;
                end else if (step_p) begin
                    state_d     = ST_STEP;
                    step_left_d = STEP_LOAD;
                end
            end
            ST_RUN: begin
                if (run_p) begin
                    state_d = ST_HALT;
                end else if (bp_hit) begin
                    state_d = ST_BREAK;
                end
            end
            ST_STEP: begin
                step_left_d = step_left_q - SW'(1);
                if (step_left_q <= SW'(1)) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase

        // Resuming on the breakpoint address must let that instruction execute once.
        if (is_stopped(state_q) && is_executing(state_d)) begin
            bp_skip_d = at_bp;
        end else if ((state_q == ST_HALT) || !at_bp) begin
            bp_skip_d = 1'b0;
        end

        cycle_cnt_d = cycle_cnt_q + {31'd0, cpu_en_w};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HALT;
            step_left_q <= '0;
            bp_skip_q   <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            step_left_q <= step_left_d;
            bp_skip_q   <= bp_skip_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign cpu_en    = cpu_en_w;
    assign state     = state_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule
